// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg: shared types and constants for the frame reader.
//   rd_state_t  - read engine states (Avalon-MM burst master side)
//   st_state_t  - stream engine states (Avalon-ST video side)
//   PKT_VIDEO / PKT_CTRL - Avalon-ST video packet type nibbles
//   INTERLACE_NIB        - interlace nibble sent in control packets
//   ctrl_beat()          - data of control packet beat 0..3
package frame_reader_pkg;

    typedef enum logic {
        R_IDLE,
        R_REQ
    } rd_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CTRL,
        S_HDR,
        S_PIX
    } st_state_t;

    localparam logic [3:0] PKT_VIDEO     = 4'h0;
    localparam logic [3:0] PKT_CTRL      = 4'hF;
    localparam logic [3:0] INTERLACE_NIB = 4'h3;

    // Three nibbles, one per 8-bit symbol, first nibble in the lowest symbol.
    function automatic logic [23:0] pack_nibbles(input logic [3:0] n0,
                                                 input logic [3:0] n1,
                                                 input logic [3:0] n2);
        return {4'h0, n2, 4'h0, n1, 4'h0, n0};
    endfunction

    // Beat 0 is the control packet header; beats 1..3 carry width, height
    // and interlace nibbles, most significant nibble first.
    function automatic logic [23:0] ctrl_beat(input logic [1:0]  idx,
                                              input logic [15:0] w,
                                              input logic [15:0] h);
        logic [23:0] beat;
        case (idx)
            2'd0:    beat = {20'h0, PKT_CTRL};
            2'd1:    beat = pack_nibbles(w[15:12], w[11:8], w[7:4]);
            2'd2:    beat = pack_nibbles(w[3:0], h[15:12], h[11:8]);
            default: beat = pack_nibbles(h[7:4], h[3:0], INTERLACE_NIB);
        endcase
        return beat;
    endfunction

endpackage

// File: rtl/frame_reader_fifo.sv
// frame_reader_fifo: 24-bit synchronous FIFO with registered output.
//   clk, reset : clock and synchronous active-high reset
//   push/wdata : write one word (caller guarantees no overflow)
//   pop        : consume the word shown on rdata (ignored when empty)
//   rdata      : registered head-of-FIFO word, valid whenever !empty
//   empty/used : status; used counts stored words (0..DEPTH)
// A word pushed at edge k is visible on rdata right after edge k.
module frame_reader_fifo #(
    parameter int DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [23:0]             wdata,
    input  logic                    pop,
    output logic [23:0]             rdata,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  used
);
    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [UW-1:0] used_reg;
    logic [UW-1:0] used_next;
    logic [UW-1:0] used_after_pop;
    logic [23:0]   rdata_reg;
    logic          do_pop;

    always_comb begin
        do_pop         = pop && (used_reg != '0);
        rd_ptr_next    = rd_ptr_reg + AW'(do_pop);
        used_after_pop = used_reg - UW'(do_pop);
        used_next      = used_after_pop + UW'(push);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            used_reg   <= '0;
            rdata_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push);
            rd_ptr_reg <= rd_ptr_next;
            used_reg   <= used_next;
            // A word written into an (effectively) empty FIFO bypasses the
            // array so it becomes the head on the very next cycle.
            if (push && used_after_pop == '0) begin
                rdata_reg <= wdata;
            end else begin
                rdata_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign rdata = rdata_reg;
    assign empty = (used_reg == '0);
    assign used  = used_reg;

endmodule

// File: rtl/frame_reader.sv
// frame_reader: streams a WIDTHxHEIGHT frame of 32-bit pixel words from
// SDRAM (Avalon-MM burst reads) to an Avalon-ST video sink (24-bit RGB).
//   clk, reset          : clock and synchronous active-high reset
//   frame_base, enable  : next frame address (sampled per frame), run enable
//   avm_*               : Avalon-MM burst read master
//   dout_*              : Avalon-ST video source, zero ready latency
//   frame_done          : high in the cycle the last pixel beat transfers
// Optional feature macro FRAME_READER_CTRL_PKT_EN: when defined, each video
// packet is preceded by a 4-beat control packet (width/height/interlace).
module frame_reader #(
    parameter int WIDTH      = 800,
    parameter int HEIGHT     = 480,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] frame_base,
    input  logic        enable,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_burstcount,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [23:0] dout_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        frame_done
);
    import frame_reader_pkg::*;

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int LW   = $clog2(NPIX + 1);
    localparam int UW   = $clog2(FIFO_DEPTH) + 1;

    // ---------------- FIFO ----------------
    logic [23:0]   fifo_rdata;
    logic          fifo_empty;
    logic [UW-1:0] fifo_used;
    logic          fifo_pop;
    logic          unused_upper;

    assign unused_upper = ^avm_readdata[31:24];

    frame_reader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (avm_readdatavalid),
        .wdata (avm_readdata[23:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .used  (fifo_used)
    );

    // ---------------- read engine ----------------
    rd_state_t     rd_state_reg;
    logic [31:0]   rd_addr_reg;
    logic [LW-1:0] rd_left_reg;
    logic [UW-1:0] outstanding_reg;
    logic [UW-1:0] outstanding_next;
    logic          avm_read_reg;
    logic [31:0]   avm_address_reg;
    logic [3:0]    avm_burstcount_reg;
    logic [3:0]    bl;
    logic [31:0]   free_words;
    logic          credit_ok;
    logic          accept;

    always_comb begin
        accept = avm_read_reg && !avm_waitrequest;
        if (32'(rd_left_reg) >= 32'(BURST_LEN)) begin
            bl = 4'(BURST_LEN);
        end else begin
            bl = 4'(rd_left_reg);
        end
        // Words already stored plus words still in flight must leave room
        // for the whole burst, so the FIFO can never overflow.
        free_words = 32'(FIFO_DEPTH) - 32'(fifo_used) - 32'(outstanding_reg);
        credit_ok  = free_words >= 32'(bl);
        outstanding_next = outstanding_reg
                         + (accept ? UW'(avm_burstcount_reg) : UW'(0))
                         - UW'(avm_readdatavalid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_reg       <= R_IDLE;
            rd_addr_reg        <= '0;
            rd_left_reg        <= '0;
            outstanding_reg    <= '0;
            avm_read_reg       <= 1'b0;
            avm_address_reg    <= '0;
            avm_burstcount_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            case (rd_state_reg)
                R_IDLE: begin
                    if (enable) begin
                        rd_addr_reg  <= frame_base;
                        rd_left_reg  <= LW'(NPIX);
                        rd_state_reg <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (avm_read_reg) begin
                        // Request held unchanged until the slave takes it.
                        if (!avm_waitrequest) begin
                            avm_read_reg <= 1'b0;
                            rd_addr_reg  <= rd_addr_reg + {26'h0, avm_burstcount_reg, 2'b00};
                            rd_left_reg  <= rd_left_reg - LW'(avm_burstcount_reg);
                        end
                    end else if (rd_left_reg == '0) begin
                        rd_state_reg <= R_IDLE;
                    end else if (credit_ok) begin
                        avm_read_reg       <= 1'b1;
                        avm_address_reg    <= rd_addr_reg;
                        avm_burstcount_reg <= bl;
                    end
                end
            endcase
        end
    end

    assign avm_read       = avm_read_reg;
    assign avm_address    = avm_address_reg;
    assign avm_burstcount = avm_burstcount_reg;

    // ---------------- stream engine ----------------
    // The dout registers hold the beat currently offered; the state names
    // which kind of beat that is.
    st_state_t     st_state_reg;
    logic [LW-1:0] pix_cnt_reg;
    logic [23:0]   dout_data_reg;
    logic          dout_valid_reg;
    logic          dout_sop_reg;
    logic          dout_eop_reg;
    logic          slot_free;
    logic          more_pix;
`ifdef FRAME_READER_CTRL_PKT_EN
    localparam logic [15:0] W16 = 16'(WIDTH);
    localparam logic [15:0] H16 = 16'(HEIGHT);
    logic [1:0]    ctrl_idx_reg;
`endif

    always_comb begin
        slot_free = !dout_valid_reg || dout_ready;
        more_pix  = (pix_cnt_reg != LW'(NPIX));
        fifo_pop  = ((st_state_reg == S_HDR) || (st_state_reg == S_PIX))
                 && slot_free && more_pix && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_state_reg   <= S_IDLE;
            pix_cnt_reg    <= '0;
            dout_data_reg  <= '0;
            dout_valid_reg <= 1'b0;
            dout_sop_reg   <= 1'b0;
            dout_eop_reg   <= 1'b0;
`ifdef FRAME_READER_CTRL_PKT_EN
            ctrl_idx_reg   <= '0;
`endif
        end else begin
            case (st_state_reg)
                S_IDLE: begin
                    pix_cnt_reg <= '0;
                    if (!fifo_empty) begin
                        dout_valid_reg <= 1'b1;
                        dout_sop_reg   <= 1'b1;
                        dout_eop_reg   <= 1'b0;
`ifdef FRAME_READER_CTRL_PKT_EN
                        ctrl_idx_reg   <= 2'd0;
                        dout_data_reg  <= ctrl_beat(2'd0, W16, H16);
                        st_state_reg   <= S_CTRL;
`else
                        dout_data_reg  <= {20'h0, PKT_VIDEO};
                        st_state_reg   <= S_HDR;
`endif
                    end
                end
                S_CTRL: begin
`ifdef FRAME_READER_CTRL_PKT_EN
                    if (dout_ready) begin
                        if (ctrl_idx_reg == 2'd3) begin
                            dout_data_reg <= {20'h0, PKT_VIDEO};
                            dout_sop_reg  <= 1'b1;
                            dout_eop_reg  <= 1'b0;
                            st_state_reg  <= S_HDR;
                        end else begin
                            ctrl_idx_reg  <= ctrl_idx_reg + 2'd1;
                            dout_data_reg <= ctrl_beat(ctrl_idx_reg + 2'd1, W16, H16);
                            dout_sop_reg  <= 1'b0;
                            dout_eop_reg  <= (ctrl_idx_reg == 2'd2);
                        end
                    end
`else
                    st_state_reg <= S_IDLE;
`endif
                end
                S_HDR, S_PIX: begin
                    if (slot_free) begin
                        if (!more_pix) begin
                            // Last pixel has just been taken.
                            dout_valid_reg <= 1'b0;
                            dout_eop_reg   <= 1'b0;
                            st_state_reg   <= S_IDLE;
                        end else if (!fifo_empty) begin
                            dout_valid_reg <= 1'b1;
                            dout_data_reg  <= fifo_rdata;
                            dout_sop_reg   <= 1'b0;
                            dout_eop_reg   <= (pix_cnt_reg == LW'(NPIX - 1));
                            pix_cnt_reg    <= pix_cnt_reg + LW'(1);
                            st_state_reg   <= S_PIX;
                        end else begin
                            dout_valid_reg <= 1'b0;
                            dout_sop_reg   <= 1'b0;
                            dout_eop_reg   <= 1'b0;
                            st_state_reg   <= S_PIX;
                        end
                    end
                end
            endcase
        end
    end

    assign dout_data  = dout_data_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_sop   = dout_sop_reg;
    assign dout_eop   = dout_eop_reg;
    // Qualified with ready so the pulse lasts exactly the transfer cycle.
    assign frame_done = dout_valid_reg && dout_ready && dout_eop_reg
                     && (st_state_reg == S_PIX);

endmodule

// File: tb/tb_frame_reader.sv
`timescale 1ns/1ps
module tb_frame_reader;
    localparam int W     = 3;
    localparam int H     = 3;
    localparam int BL    = 4;
    localparam int DEPTH = 8;
    localparam int N     = W * H;
    localparam int BPF   = (N + BL - 1) / BL;
    localparam int MAXC  = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] frame_base;
    logic        enable;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [23:0] dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_sop;
    logic        dout_eop;
    logic        frame_done;

    always #5 clk = ~clk;

    frame_reader #(.WIDTH(W), .HEIGHT(H), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_base        (frame_base),
        .enable            (enable),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .dout_data         (dout_data),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .dout_sop          (dout_sop),
        .dout_eop          (dout_eop),
        .frame_done        (frame_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents: pixel value derived from the word address.
    function automatic logic [23:0] pix_of(input logic [31:0] a);
        return 24'((a >> 2) * 32'd40503 + 32'd7);
    endfunction

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  cnt;
    } burst_t;

    beat_t       exp_beats[$];
    burst_t      exp_bursts[$];
    logic [31:0] ret_q[$];
    logic [31:0] bases[8];

    // monitor state
    int          cyc;
    int          burst_idx;
    int          acc_words;
    int          pix_out;
    int          nframes;
    int          stall_left;
    logic        stall_given;
    logic        av_hold;
    logic [31:0] av_addr_h;
    logic [3:0]  av_bc_h;
    logic        st_hold;
    logic [23:0] st_data_h;
    logic        st_sop_h;
    logic        st_eop_h;

    // One clock cycle: drive inputs at negedge, then evaluate what the
    // coming posedge will transfer.
    task automatic step(input int wmode, input int rmode);
        burst_t b;
        beat_t  e;
        logic   exp_fd;
        @(negedge clk);
        case (rmode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = (cyc % 2 == 0);
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        case (wmode)
            0:       avm_waitrequest = 1'b0;
            1:       avm_waitrequest = 1'($urandom_range(0, 1));
            default: begin
                if (avm_read && !stall_given) begin
                    stall_left  = 5;
                    stall_given = 1'b1;
                end
                avm_waitrequest = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end
        endcase
        if (ret_q.size() > 0 && (wmode == 0 || $urandom_range(0, 3) != 0)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = ret_q.pop_front();
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end
        #1;
        if (av_hold) begin
            check("avm_read_held", 32'(avm_read), 32'h1);
            check("avm_address_held", avm_address, av_addr_h);
            check("avm_burstcount_held", 32'(avm_burstcount), 32'(av_bc_h));
        end
        if (st_hold) begin
            check("dout_valid_held", 32'(dout_valid), 32'h1);
            check("dout_data_held", 32'(dout_data), 32'(st_data_h));
            check("dout_sop_held", 32'(dout_sop), 32'(st_sop_h));
            check("dout_eop_held", 32'(dout_eop), 32'(st_eop_h));
        end
        if (avm_read && !avm_waitrequest) begin
            if (exp_bursts.size() == 0) begin
                check("unexpected_burst", avm_address, 32'hFFFF_FFFF);
            end else begin
                b = exp_bursts.pop_front();
                check("burst_addr", avm_address, b.addr);
                check("burst_count", 32'(avm_burstcount), 32'(b.cnt));
                for (int i = 0; i < int'(avm_burstcount); i++) begin
                    ret_q.push_back({8'($urandom), pix_of(avm_address + 32'(4 * i))});
                end
                acc_words += int'(avm_burstcount);
                checks++;
                if (acc_words - pix_out > DEPTH + 1) begin
                    errors++;
                    $display("FAIL credit: %0d words buffered or in flight, limit %0d",
                             acc_words - pix_out, DEPTH + 1);
                end
                $display("burst %0d addr=0x%08h count=%0d", burst_idx, avm_address, avm_burstcount);
                // Frame k has started reading: present the next base now,
                // or stop after the last frame.
                if (burst_idx % BPF == 0) begin
                    if (burst_idx / BPF + 1 < nframes) frame_base = bases[burst_idx / BPF + 1];
                    else enable = 1'b0;
                end
                burst_idx++;
            end
            stall_given = 1'b0;
        end
        av_hold   = avm_read && avm_waitrequest;
        av_addr_h = avm_address;
        av_bc_h   = avm_burstcount;
        exp_fd = 1'b0;
        if (dout_valid && dout_ready) begin
            if (exp_beats.size() == 0) begin
                check("unexpected_beat", 32'(dout_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_beats.pop_front();
                check("beat_data", 32'(dout_data), 32'(e.data));
                check("beat_sop", 32'(dout_sop), 32'(e.sop));
                check("beat_eop", 32'(dout_eop), 32'(e.eop));
                exp_fd = e.last;
                if (!e.sop && !(e.eop && !e.last)) pix_out++;
                if (e.last) $display("frame done at cycle %0d", cyc);
            end
        end
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        st_hold   = dout_valid && !dout_ready;
        st_data_h = dout_data;
        st_sop_h  = dout_sop;
        st_eop_h  = dout_eop;
        cyc++;
    endtask

    task automatic build_frame(input logic [31:0] base);
        beat_t e;
`ifdef FRAME_READER_CTRL_PKT_EN
        logic [15:0] w16;
        logic [15:0] h16;
        int          nib[9];
        w16 = 16'(W);
        h16 = 16'(H);
        for (int i = 0; i < 4; i++) begin
            nib[i]     = int'((w16 >> (12 - 4 * i)) & 16'hF);
            nib[4 + i] = int'((h16 >> (12 - 4 * i)) & 16'hF);
        end
        nib[8] = 3;
        exp_beats.push_back('{data: 24'hF, sop: 1'b1, eop: 1'b0, last: 1'b0});
        for (int j = 0; j < 3; j++) begin
            e.data = 24'(nib[3 * j] + nib[3 * j + 1] * 256 + nib[3 * j + 2] * 65536);
            e.sop  = 1'b0;
            e.eop  = (j == 2);
            e.last = 1'b0;
            exp_beats.push_back(e);
        end
`endif
        exp_beats.push_back('{data: 24'h0, sop: 1'b1, eop: 1'b0, last: 1'b0});
        for (int i = 0; i < N; i++) begin
            e.data = pix_of(base + 32'(4 * i));
            e.sop  = 1'b0;
            e.eop  = (i == N - 1);
            e.last = (i == N - 1);
            exp_beats.push_back(e);
        end
        for (int k = 0; k < N; k += BL) begin
            exp_bursts.push_back('{addr: base + 32'(4 * k), cnt: 4'((N - k < BL) ? N - k : BL)});
        end
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset             = 1'b1;
            enable            = 1'b1;
            avm_waitrequest   = 1'($urandom_range(0, 1));
            avm_readdatavalid = 1'b1;
            avm_readdata      = $urandom;
            dout_ready        = 1'b1;
        end
    endtask

    task automatic run_cfg(input int wmode, input int rmode, input int frames);
        exp_beats.delete();
        exp_bursts.delete();
        ret_q.delete();
        nframes = frames;
        for (int k = 0; k < frames; k++) begin
            if (k == 0)      bases[k] = 32'h1000;
            else if (k == 1) bases[k] = 32'h2000;
            else             bases[k] = 32'($urandom) & 32'h00FF_FFFC;
            build_frame(bases[k]);
        end
        hold_reset(2);
        cyc = 0; burst_idx = 0; acc_words = 0; pix_out = 0;
        stall_left = 0; stall_given = 1'b0; av_hold = 1'b0; st_hold = 1'b0;
        @(negedge clk);
        reset             = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b1;
        enable            = 1'b1;
        frame_base        = bases[0];
        $display("run wmode=%0d rmode=%0d frames=%0d", wmode, rmode, frames);
        while (exp_beats.size() > 0 && cyc < MAXC) step(wmode, rmode);
        check("run_timeout_beats_left", 32'(exp_beats.size()), 32'h0);
        // Enable is low now: nothing more may be requested or emitted.
        for (int i = 0; i < 20; i++) step(wmode, rmode);
        check("bursts_left", 32'(exp_bursts.size()), 32'h0);
        check("readdata_left", 32'(ret_q.size()), 32'h0);
        check("idle_valid", 32'(dout_valid), 32'h0);
    endtask

    typedef struct {
        logic       en;
        int         cyc;
        logic       exp_read;
        logic [3:0] exp_bc;
    } rst_vec_t;

    typedef struct {
        int wmode;
        int rmode;
        int frames;
    } cfg_t;

    rst_vec_t rv[5];
    cfg_t     cfgs[5];

    initial begin
        logic [31:0] base;
        reset = 1'b1; enable = 1'b0; frame_base = 32'h0;
        avm_waitrequest = 1'b0; avm_readdata = 32'h0; avm_readdatavalid = 1'b0;
        dout_ready = 1'b1;

        rv[0] = '{1'b0, 1, 1'b0, 4'd0};
        rv[1] = '{1'b0, 4, 1'b0, 4'd0};
        rv[2] = '{1'b1, 1, 1'b0, 4'd0};
        rv[3] = '{1'b1, 2, 1'b1, 4'd4};
        rv[4] = '{1'b1, 7, 1'b1, 4'd4};

        cfgs[0] = '{0, 0, 3};
        cfgs[1] = '{0, 1, 3};
        cfgs[2] = '{1, 2, 3};
        cfgs[3] = '{2, 0, 2};
        cfgs[4] = '{1, 1, 3};

        // Reset state, with busy-looking inputs held during reset.
        hold_reset(3);
        #1;
        check("rst_avm_read", 32'(avm_read), 32'h0);
        check("rst_avm_burstcount", 32'(avm_burstcount), 32'h0);
        check("rst_avm_address", avm_address, 32'h0);
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        check("rst_dout_sop", 32'(dout_sop), 32'h0);
        check("rst_dout_eop", 32'(dout_eop), 32'h0);
        check("rst_dout_data", 32'(dout_data), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);

        // First-request latency and request stability under waitrequest.
        for (int i = 0; i < 5; i++) begin
            hold_reset(2);
            base = 32'($urandom) & 32'hFFFF_FFFC;
            @(negedge clk);
            reset             = 1'b0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b1;
            enable            = rv[i].en;
            frame_base        = base;
            for (int c = 0; c < rv[i].cyc; c++) @(negedge clk);
            #1;
            check("vec_avm_read", 32'(avm_read), 32'(rv[i].exp_read));
            check("vec_avm_address", avm_address, rv[i].exp_read ? base : 32'h0);
            check("vec_avm_burstcount", 32'(avm_burstcount), 32'(rv[i].exp_bc));
            check("vec_dout_valid", 32'(dout_valid), 32'h0);
            $display("vector %0d en=%0d cycle=%0d read=%0d addr=0x%08h", i, rv[i].en,
                     rv[i].cyc, avm_read, avm_address);
        end

        for (int i = 0; i < 5; i++) run_cfg(cfgs[i].wmode, cfgs[i].rmode, cfgs[i].frames);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
